// File: rtl/axil_reg_pkg.sv
// Shared definitions for the AXI-Lite register arbiter: FSM states and
// AXI response codes.
package axil_reg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] WSTRB_ALL   = 4'hF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the search begins just after the
// previous winner and wraps, yielding a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Walk every offset once; the first hit after last_grant wins.
  always_comb begin
    logic             found;
    logic             hit;
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    hit   = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand        = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      hit         = req[cand] & ~found;
      grant[cand] = hit;
      idx         = hit ? cand : idx;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Serialises several register requesters onto a single AXI-Lite master
// with at most one transaction in flight.
module axil_reg_arbiter
  import axil_reg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      axil_aclk,
  input  logic                      axil_aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [1:0]                resp_err,
  output logic                      m_axil_awvalid,
  output logic [ADDR_W-1:0]         m_axil_awaddr,
  input  logic                      m_axil_awready,
  output logic                      m_axil_wvalid,
  output logic [DATA_W-1:0]         m_axil_wdata,
  output logic [3:0]                m_axil_wstrb,
  input  logic                      m_axil_wready,
  input  logic                      m_axil_bvalid,
  input  logic [1:0]                m_axil_bresp,
  output logic                      m_axil_bready,
  output logic                      m_axil_arvalid,
  output logic [ADDR_W-1:0]         m_axil_araddr,
  input  logic                      m_axil_arready,
  input  logic                      m_axil_rvalid,
  input  logic [DATA_W-1:0]         m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  output logic                      m_axil_rready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (win_idx)
  );

  // The grant is combinational so the winner sees req_ready in its request cycle.
  assign req_ready     = (state == IDLE && axil_aresetn) ? grant : '0;
  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = WSTRB_ALL;

  // Transaction FSM with all AXI handshake outputs registered.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(NUM_REQ - 1);
      owner          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      resp_valid     <= '0;
      resp_rdata     <= '0;
      resp_err       <= RESP_OKAY;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            last_grant <= win_idx;
            owner      <= win_idx;
            addr_q     <= req_addr[win_idx*ADDR_W +: ADDR_W];
            wdata_q    <= req_wdata[win_idx*DATA_W +: DATA_W];
            if (req_we[win_idx]) begin
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= WR_REQ;
            end else begin
              m_axil_arvalid <= 1'b1;
              state          <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          // Leave once each channel is either already done or completing now.
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            resp_valid    <= NUM_REQ'(1) << owner;
            resp_err      <= m_axil_bresp;
            state         <= IDLE;
          end
        end
        RD_REQ: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            resp_valid    <= NUM_REQ'(1) << owner;
            resp_rdata    <= m_axil_rdata;
            resp_err      <= m_axil_rresp;
            state         <= IDLE;
          end
        end
        default: begin
          m_axil_awvalid <= 1'b0;
          m_axil_wvalid  <= 1'b0;
          m_axil_bready  <= 1'b0;
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter with a behavioural AXI-Lite slave
// and a completion scoreboard.
module tb_axil_reg_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we    = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic [1:0]                resp_err;

  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  axil_reg_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .axil_aclk(clk), .axil_aresetn(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
    .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wready(wready), .m_axil_bvalid(bvalid), .m_axil_bresp(bresp),
    .m_axil_bready(bready), .m_axil_arvalid(arvalid), .m_axil_araddr(araddr),
    .m_axil_arready(arready), .m_axil_rvalid(rvalid), .m_axil_rdata(rdata),
    .m_axil_rresp(rresp), .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slave ----------------
  logic [3:0]  aw_dly = 4'd0, w_dly = 4'd0, ar_dly = 4'd0, r_dly = 4'd0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [3:0]  aw_wait, w_wait, ar_wait, r_cnt;
  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_l, w_l, r_addr;
  logic [31:0] mem [0:255];
  int          aw_hs = 0, w_hs = 0;

  assign awready = (aw_wait == 4'd0);
  assign wready  = (w_wait == 4'd0);
  assign arready = (ar_wait == 4'd0);

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] wa, wd;
    if (!rst_n) begin
      aw_wait <= aw_dly; w_wait <= w_dly; ar_wait <= ar_dly; r_cnt <= 4'd0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'd0;
    end else begin
      if (!awvalid) aw_wait <= aw_dly;
      else if (awready) begin aw_got <= 1'b1; aw_l <= awaddr; aw_hs <= aw_hs + 1; end
      else aw_wait <= aw_wait - 4'd1;
      if (!wvalid) w_wait <= w_dly;
      else if (wready) begin w_got <= 1'b1; w_l <= wdata; w_hs <= w_hs + 1; end
      else w_wait <= w_wait - 4'd1;
      wa = aw_got ? aw_l : awaddr;
      wd = w_got ? w_l : wdata;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        bvalid <= 1'b1; bresp <= bresp_cfg; mem[wa[9:2]] <= wd;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (!arvalid) ar_wait <= ar_dly;
      else if (arready) begin
        if (r_dly == 4'd0) begin rvalid <= 1'b1; rdata <= mem[araddr[9:2]]; rresp <= rresp_cfg; end
        else begin r_pend <= 1'b1; r_cnt <= r_dly - 4'd1; r_addr <= araddr; end
      end else ar_wait <= ar_wait - 4'd1;
      if (r_pend) begin
        if (r_cnt == 4'd0) begin rvalid <= 1'b1; rdata <= mem[r_addr[9:2]]; rresp <= rresp_cfg; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 4'd1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic        is_rd;
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_resp_valid", 64'(resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_owner", 64'(resp_valid), 64'(NUM_REQ'(1) << e.owner));
        check("resp_err", 64'(resp_err), 64'(e.err));
        if (e.is_rd) check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int r, input logic is_rd, input logic [31:0] d, input logic [1:0] err);
    exp_t e;
    e.owner = r; e.is_rd = is_rd; e.rdata = d; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r*ADDR_W +: ADDR_W]  = a;
    req_wdata[r*DATA_W +: DATA_W] = d;
  endtask

  // Waits (bounded) for any grant at a negedge and returns it.
  task automatic wait_grant(output logic [NUM_REQ-1:0] g);
    g = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready !== '0) begin g = req_ready; break; end
    end
  endtask

  task automatic issue(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [NUM_REQ-1:0] g;
    @(posedge clk); #1;
    set_req(r, we, a, d);
    wait_grant(g);
    check("issue_grant", 64'(g), 64'(NUM_REQ'(1) << r));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [NUM_REQ-1:0] g;
    int aw0, w0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rst_rdata", 64'(resp_rdata), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    rst_n = 1'b1;

    // Single write, zero-wait slave: AW/W in cycle 1, response in cycle 3.
    push(0, 1'b0, 32'd0, 2'b00);
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_c1_valids", 64'({awvalid, wvalid}), 64'h3);
    check("wr_c1_wstrb", 64'(wstrb), 64'hF);
    check("wr_c1_awaddr", 64'(awaddr), 64'h10);
    check("wr_c1_wdata", 64'(wdata), 64'hDEAD_BEEF);
    check("wr_c1_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("wr_c2_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check("wr_c3_resp_valid", 64'(resp_valid), 64'h1);
    drain();

    // Read-back by requester 1.
    push(1, 1'b1, 32'hDEAD_BEEF, 2'b00);
    issue(1, 1'b0, 32'h0000_0010, 32'd0);
    drain();

    // Both requesters held high: round-robin 0,1,0,1.
    for (int k = 0; k < 4; k++) push(k % 2, 1'b0, 32'd0, 2'b00);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h0000_0040, 32'h1111_0000);
    set_req(1, 1'b1, 32'h0000_0044, 32'h2222_0000);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check("rr_grant", 64'(g), 64'(NUM_REQ'(1) << (k % 2)));
      if (k == 3) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
    end
    drain();

    // AW accepted 3 cycles before W.
    aw0 = aw_hs; w0 = w_hs;
    w_dly = 4'd3;
    push(1, 1'b0, 32'd0, 2'b00);
    issue(1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    check("aww_c1_valids", 64'({awvalid, wvalid}), 64'h3);
    @(negedge clk);
    check("aww_c2_awvalid", 64'(awvalid), 64'd0);
    check("aww_c2_wvalid", 64'(wvalid), 64'd1);
    @(negedge clk);
    check("aww_c3_wdata_stable", 64'(wdata), 64'hCAFE_F00D);
    drain();
    check("aww_aw_count", 64'(aw_hs - aw0), 64'd1);
    check("aww_w_count", 64'(w_hs - w0), 64'd1);
    w_dly = 4'd0;

    // SLVERR on write then on read.
    bresp_cfg = 2'b10;
    push(1, 1'b0, 32'd0, 2'b10);
    issue(1, 1'b1, 32'h0000_0030, 32'h5A5A_A5A5);
    drain();
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b10;
    push(0, 1'b1, 32'h5A5A_A5A5, 2'b10);
    issue(0, 1'b0, 32'h0000_0030, 32'd0);
    drain();
    rresp_cfg = 2'b00;

    // Reset while in RD_RESP: transaction dropped, req0 wins afterwards.
    r_dly = 4'd6;
    issue(0, 1'b0, 32'h0000_0010, 32'd0);
    for (int i = 0; i < 20 && rready !== 1'b1; i++) @(negedge clk);
    check("rst_mid_in_rd_resp", 64'(rready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_arvalid", 64'(arvalid), 64'd0);
    check("rst_mid_rready", 64'(rready), 64'd0);
    check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    r_dly = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    push(0, 1'b0, 32'd0, 2'b00);
    push(1, 1'b0, 32'd0, 2'b00);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h0000_0050, 32'h0000_0001);
    set_req(1, 1'b1, 32'h0000_0054, 32'h0000_0002);
    wait_grant(g);
    check("post_rst_grant0", 64'(g), 64'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_grant(g);
    check("post_rst_grant1", 64'(g), 64'h2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_arbiter.md
AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 The block SHALL take these parameters, one per line:
  - NUM_REQ, 2, number of requesters (2..8)
  - ADDR_W, 32, AXI-Lite address width
  - DATA_W, 32, AXI-Lite data width (fixed 32)
REQ-002 The block SHALL have these ports, one per line:
  - axil_aclk  in  1  sole clock
  - axil_aresetn  in  1  asynchronous, active-low reset
  - req_valid  in  NUM_REQ  per-requester request valid
  - req_ready  out  NUM_REQ  per-requester request accepted (one-hot)
  - req_we  in  NUM_REQ  1 = write, 0 = read
  - req_addr  in  NUM_REQ*ADDR_W  packed request addresses
  - req_wdata  in  NUM_REQ*DATA_W  packed write data
  - resp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
  - resp_rdata  out  DATA_W  read data, shared by all requesters
  - resp_err  out  2  BRESP/RRESP of the completed transaction
  - m_axil_aw*/w*/b*/ar*/r*  various  AXI-Lite master port: awvalid, awaddr[ADDR_W], awready, wvalid, wdata[32], wstrb[4], wready, bvalid, bresp[2], bready, arvalid, araddr[ADDR_W], arready, rvalid, rdata[32], rresp[2], rready

Function
REQ-003 The block SHALL serialise requesters onto one AXI-Lite master, with at most one transaction outstanding.
REQ-004 The FSM SHALL use five states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
REQ-005 In IDLE with any req_valid high, the block SHALL assert req_ready for exactly one winner in the same cycle and capture we/addr/wdata; it SHALL go to WR_REQ if we=1, else RD_REQ.
REQ-006 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-007 In WR_REQ the block SHALL assert awvalid and wvalid from the first cycle, with wstrb=4'hF.
REQ-008 In WR_REQ each valid SHALL drop independently after its own handshake; AW and W may complete in either order or in the same cycle.
REQ-009 WR_REQ SHALL exit to WR_RESP only when both AW and W have completed.
REQ-010 In WR_RESP the block SHALL hold bready=1; on bvalid it SHALL pulse resp_valid[owner] for 1 cycle with resp_err=bresp and return to IDLE.
REQ-011 In RD_REQ the block SHALL hold arvalid until arready, then go to RD_RESP.
REQ-012 In RD_RESP the block SHALL hold rready=1; on rvalid it SHALL pulse resp_valid[owner] with resp_rdata=rdata and resp_err=rresp, then return to IDLE.
REQ-013 resp_rdata SHALL be registered and held until the next read completion; for writes it is don't-care.
REQ-014 Once asserted, AXI valids and payloads SHALL stay stable until their handshake.
REQ-015 req_ready SHALL be low in every state except IDLE.
REQ-016 Minimum latency SHALL be: grant cycle, then 1 cycle address handshake, then 1 cycle response, giving resp_valid on the 3rd cycle after the grant edge with a zero-wait slave.
REQ-017 A new grant SHALL be possible in the cycle after resp_valid.
REQ-018 req_valid dropped by a losing requester SHALL NOT affect the current transaction.

Reset
REQ-019 When axil_aresetn is low, the block SHALL asynchronously force: state=IDLE, last_grant=NUM_REQ-1, all valids/readies/resp_valid=0, resp_rdata=0, resp_err=0.
REQ-020 Reset mid-transaction SHALL abandon the transaction without any resp_valid.
REQ-021 Deassertion SHALL be sampled synchronously to axil_aclk.

Structure
REQ-022 The FSM state enum and the AXI resp codes (OKAY=2'b00, SLVERR=2'b10) SHALL live in shared package axil_reg_pkg.
REQ-023 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, index).

Verification
REQ-024 The bench SHALL cover:
  - Single write, req0 addr 0x010, data 0xDEADBEEF, zero-wait slave -> awvalid/wvalid in cycle 1, resp_valid[0] in cycle 3, resp_err=0.
  - Read-back of req1 addr 0x010 -> resp_valid[1], resp_rdata=0xDEADBEEF.
  - req0 and req1 both held high for 4 transactions -> grants 0,1,0,1.
  - awready 3 cycles before wready -> awvalid drops after AW handshake, wvalid holds, exactly one AW and one W.
  - aresetn low while in RD_RESP -> arvalid/rready=0 immediately, no resp_valid, next grant goes to req0.
  - Slave bresp=2'b10 -> resp_err=2'b10 with resp_valid.
